// File: rtl/fetch_pkg.sv
// Shared types and defaults for the instruction-fetch slice.
// State encoding, NOP word and default memory/PC constants.
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    HALT  = 2'd2,
    FAULT = 2'd3
  } state_t;

  localparam logic [31:0] NOP = 32'h0;
  localparam int IMEM_WORDS_DEF = 1024;
  localparam logic [31:0] RESET_PC_DEF = 32'h0;

endpackage

// File: rtl/fetch_queue.sv
// Small FIFO of {pc, inst} entries between fetch and decode.
// Flush dominates; push and pop together on a full queue is legal.
module fetch_queue #(
  parameter int W     = 64,
  parameter int DEPTH = 2,
  localparam int PW   = $clog2(DEPTH),
  localparam int CW   = PW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic          pop,
  input  logic          flush,
  input  logic [W-1:0]  din,
  output logic [W-1:0]  dout,
  output logic [CW-1:0] count
);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;

  // Storage is cleared on reset so an empty head never shows X.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + PW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  assign dout = mem[rd_ptr];

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch controller: owns the PC, reads imem, queues words to decode.
// Handles redirect, halt, out-of-range fault and decode stall count.
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int DEPTH      = 2,
  parameter int IMEM_WORDS = IMEM_WORDS_DEF,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEF)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en_i,
  input  logic              halt_i,
  input  logic              redirect_i,
  input  logic [ADDR_W-1:0] redirect_pc_i,
  output logic [ADDR_W-1:0] imem_addr_o,
  input  logic [DATA_W-1:0] imem_rdata_i,
  output logic              inst_valid_o,
  input  logic              inst_ready_i,
  output logic [DATA_W-1:0] inst_o,
  output logic [ADDR_W-1:0] inst_pc_o,
  output logic              fault_o,
  output logic [15:0]       stall_cnt_o
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [ADDR_W-1:0] LIMIT = ADDR_W'(IMEM_WORDS);

  state_t state, state_nx;

  logic [ADDR_W-1:0]        fpc;
  logic [CW-1:0]            count;
  logic [ADDR_W+DATA_W-1:0] head;
  logic in_range;
  logic pop;
  logic room;
  logic want;
  logic fire;

  assign in_range = {2'b00, fpc[ADDR_W-1:2]} < LIMIT;
  assign pop      = inst_valid_o && inst_ready_i;
  assign room     = (count < CW'(DEPTH)) || pop;
  assign want     = (state == RUN) && en_i && !halt_i
                    && !redirect_i && room;
  assign fire     = want && in_range;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    if (redirect_i) begin
      state_nx = (state == IDLE) ? IDLE : RUN;
    end else begin
      unique case (state)
        IDLE:  if (en_i) state_nx = RUN;
        RUN: begin
          if (halt_i)                state_nx = HALT;
          else if (want && !in_range) state_nx = FAULT;
        end
        HALT:  state_nx = HALT;
        FAULT: state_nx = FAULT;
        default: state_nx = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      fpc <= RESET_PC;
    else if (redirect_i)
      fpc <= {redirect_pc_i[ADDR_W-1:2], 2'b00};
    else if (fire)
      fpc <= fpc + ADDR_W'(4);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      stall_cnt_o <= '0;
    else if (inst_valid_o && !inst_ready_i && stall_cnt_o != 16'hFFFF)
      stall_cnt_o <= stall_cnt_o + 16'd1;
  end

  fetch_queue #(
    .W     (ADDR_W + DATA_W),
    .DEPTH (DEPTH)
  ) u_queue (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (fire),
    .pop   (pop),
    .flush (redirect_i),
    .din   ({fpc, imem_rdata_i}),
    .dout  (head),
    .count (count)
  );

  assign imem_addr_o          = fpc;
  assign inst_valid_o         = (count != '0);
  assign {inst_pc_o, inst_o}  = head;
  assign fault_o              = (state == FAULT);

endmodule
